// File: rtl/sdram_bus_if.sv
// sdram_bus: toggle-handshake link between an SDRAM requester and a memory
// provider. A request is pending while req != ack. The requester owns req and
// the command fields; the provider owns ack and data_read.
//
// Signals:
//   req         request toggle (requester)
//   ack         acknowledge toggle (provider)
//   we          1 = write, 0 = read
//   address     word address [ADDR_BITS-1:0]
//   data_write  write data [15:0]
//   wm          byte write mask [1:0]
//   data_read   read data [15:0], valid when ack toggles after a read
//
// Modports:
//   memory      the provider side (arbiter facing a client)
//   controller  the requester side (arbiter facing the SDRAM controller)
interface sdram_bus #(
  parameter int ADDR_BITS = 22
);
  logic                 req;
  logic                 ack;
  logic                 we;
  logic [ADDR_BITS-1:0] address;
  logic [15:0]          data_write;
  logic [1:0]           wm;
  logic [15:0]          data_read;

  modport memory (
    input  req, we, address, data_write, wm,
    output ack, data_read
  );

  modport controller (
    output req, we, address, data_write, wm,
    input  ack, data_read
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants one of three toggle-handshake clients (c0 = CHR,
// c1 = PRG, c2 = loader/MCU) access to a single SDRAM controller. The granted
// command is latched onto mem, and on completion read data and the client's
// ack toggle are returned in the same cycle.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high; abandons any in-flight transaction
//   c0..c2 sdram_bus.memory     client links (arbiter owns ack/data_read)
//   mem    sdram_bus.controller downstream link (arbiter owns req/command)
//
// Configuration:
//   SDRAM_ARB_CH0_PRIORITY_EN  when defined, c0 wins whenever pending and
//                              c1/c2 alternate between themselves; otherwise
//                              the three clients are served round-robin.
module sdram_arbiter #(
  parameter int ADDR_BITS = 22
) (
  input  logic         clk,
  input  logic         reset,
  sdram_bus.memory     c0,
  sdram_bus.memory     c1,
  sdram_bus.memory     c2,
  sdram_bus.controller mem
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [1:0]           grant_q;   // client owning the in-flight transaction
  logic [1:0]           grant;     // client that would be granted this cycle
  logic [2:0]           pend;

  logic                 sel_we;
  logic [ADDR_BITS-1:0] sel_address;
  logic [15:0]          sel_data_write;
  logic [1:0]           sel_wm;

  assign pend = {c2.req ^ c2.ack, c1.req ^ c1.ack, c0.req ^ c0.ack};

`ifdef SDRAM_ARB_CH0_PRIORITY_EN
  // Set when c2 was the more recently served of the c1/c2 pair.
  logic last_hi;

  always_comb begin
    // NOTE: every combinational output gets a value on every path (here by
    // the exhaustive if/else chain), otherwise synthesis infers a latch.
    if (pend[0])                 grant = 2'd0;
    else if (pend[1] && pend[2]) grant = last_hi ? 2'd1 : 2'd2;
    else if (pend[1])            grant = 2'd1;
    else                         grant = 2'd2;
  end
`else
  logic [1:0] last;              // client served most recently
  logic [1:0] rr_first, rr_second;

  // Round-robin search starts just after the last served client, mod 3.
  assign rr_first  = (last == 2'd2)     ? 2'd0 : last + 2'd1;
  assign rr_second = (rr_first == 2'd2) ? 2'd0 : rr_first + 2'd1;

  always_comb begin
    // NOTE: every combinational output gets a value on every path (here by
    // the exhaustive if/else chain), otherwise synthesis infers a latch.
    if (pend[rr_first])       grant = rr_first;
    else if (pend[rr_second]) grant = rr_second;
    else                      grant = last;
  end
`endif

  // Command fields of the candidate client.
  always_comb begin
    sel_we         = c0.we;
    sel_address    = c0.address;
    sel_data_write = c0.data_write;
    sel_wm         = c0.wm;
    case (grant)
      2'd1: begin
        sel_we         = c1.we;
        sel_address    = c1.address;
        sel_data_write = c1.data_write;
        sel_wm         = c1.wm;
      end
      2'd2: begin
        sel_we         = c2.we;
        sel_address    = c2.address;
        sel_data_write = c2.data_write;
        sel_wm         = c2.wm;
      end
      default: ;
    endcase
  end

  // NOTE: all state here is registered with non-blocking assignments so every
  // flop samples pre-edge values; blocking assignments would create ordering
  // races between flops in simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Re-align every toggle pair: pending requests are dropped and no
      // downstream transaction is considered outstanding.
      c0.ack       <= c0.req;
      c1.ack       <= c1.req;
      c2.ack       <= c2.req;
      c0.data_read <= '0;
      c1.data_read <= '0;
      c2.data_read <= '0;
      mem.req      <= mem.ack;
      mem.we       <= 1'b0;
      mem.wm       <= 2'b00;
      grant_q      <= 2'd0;
      state        <= IDLE;
`ifdef SDRAM_ARB_CH0_PRIORITY_EN
      last_hi      <= 1'b1;
`else
      last         <= 2'd2;
`endif
      // NOTE: address and data_write are pure datapath captured at grant;
      // they are never read before a grant loads them, so they carry no reset.
    end else begin
      case (state)
        IDLE: begin
          if (|pend) begin
            mem.we         <= sel_we;
            mem.address    <= sel_address;
            mem.data_write <= sel_data_write;
            mem.wm         <= sel_wm;
            mem.req        <= ~mem.req;
            grant_q        <= grant;
            state          <= BUSY;
          end
        end
        BUSY: begin
          if (mem.ack == mem.req) begin
            // Read data lands in the same cycle the client's ack toggles;
            // writes leave the client's data_read untouched.
            case (grant_q)
              2'd0: begin
                c0.ack <= ~c0.ack;
                if (!mem.we) c0.data_read <= mem.data_read;
              end
              2'd1: begin
                c1.ack <= ~c1.ack;
                if (!mem.we) c1.data_read <= mem.data_read;
              end
              2'd2: begin
                c2.ack <= ~c2.ack;
                if (!mem.we) c2.data_read <= mem.data_read;
              end
              default: ;
            endcase
`ifdef SDRAM_ARB_CH0_PRIORITY_EN
            if (grant_q != 2'd0) last_hi <= (grant_q == 2'd2);
`else
            last <= grant_q;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: directed table of single transactions, hand
// sequences for contention, request-while-busy and reset-while-busy, then a
// randomized run checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_sdram_arbiter;
  localparam int AB = 22;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Client-side drive
  logic [2:0]    cl_req;
  logic [2:0]    cl_we;
  logic [AB-1:0] cl_addr [3];
  logic [15:0]   cl_dw   [3];
  logic [1:0]    cl_wm   [3];
  logic [2:0]    ack_w;
  logic [15:0]   dr_w    [3];

  // Downstream controller model drive
  logic          m_ack;
  logic [15:0]   m_rdata;
  int            lat = 2;
  logic [AB-1:0] log_addr [$];
  int            log_cyc  [$];

  sdram_bus #(.ADDR_BITS(AB)) c0_if ();
  sdram_bus #(.ADDR_BITS(AB)) c1_if ();
  sdram_bus #(.ADDR_BITS(AB)) c2_if ();
  sdram_bus #(.ADDR_BITS(AB)) mem_if ();

  assign c0_if.req = cl_req[0];  assign c0_if.we = cl_we[0];  assign c0_if.address = cl_addr[0];
  assign c0_if.data_write = cl_dw[0];  assign c0_if.wm = cl_wm[0];
  assign c1_if.req = cl_req[1];  assign c1_if.we = cl_we[1];  assign c1_if.address = cl_addr[1];
  assign c1_if.data_write = cl_dw[1];  assign c1_if.wm = cl_wm[1];
  assign c2_if.req = cl_req[2];  assign c2_if.we = cl_we[2];  assign c2_if.address = cl_addr[2];
  assign c2_if.data_write = cl_dw[2];  assign c2_if.wm = cl_wm[2];
  assign ack_w[0] = c0_if.ack;  assign dr_w[0] = c0_if.data_read;
  assign ack_w[1] = c1_if.ack;  assign dr_w[1] = c1_if.data_read;
  assign ack_w[2] = c2_if.ack;  assign dr_w[2] = c2_if.data_read;
  assign mem_if.ack = m_ack;
  assign mem_if.data_read = m_rdata;

  sdram_arbiter #(.ADDR_BITS(AB)) dut (
    .clk   (clk),
    .reset (reset),
    .c0    (c0_if),
    .c1    (c1_if),
    .c2    (c2_if),
    .mem   (mem_if)
  );

  // Read data returned by the controller model for a given address.
  function automatic logic [15:0] data_for(input logic [AB-1:0] a);
    return a[15:0] ^ 16'hACDB;
  endfunction

  // SDRAM controller model: accepts a toggle, answers after `lat` cycles,
  // drops the transaction if reset is seen meanwhile.
  initial begin
    logic [AB-1:0] cap;
    bit aborted;
    int n;
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset && mem_if.req !== m_ack) begin
        cap = mem_if.address;
        log_addr.push_back(cap);
        log_cyc.push_back(cyc);
        aborted = 0;
        n = lat;
        for (int i = 0; i < n && !aborted; i++) begin
          @(posedge clk);
          if (reset) aborted = 1;
        end
        if (!aborted) begin
          #1;
          m_rdata = data_for(cap);
          m_ack = ~m_ack;
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            client;
    logic          we;
    logic [AB-1:0] addr;
    logic [15:0]   dw;
    logic [1:0]    wm;
    int            lat;
    logic [15:0]   exp_dr;
  } vec_t;

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One isolated transaction with cycle-exact latency checks.
  task automatic do_single(input int idx, input vec_t v);
    logic old_ack, mreq0;
    bit seen;
    int c;
    c = v.client;
    @(posedge clk); #1;
    lat = v.lat;
    cl_we[c] = v.we; cl_addr[c] = v.addr; cl_dw[c] = v.dw; cl_wm[c] = v.wm;
    old_ack = ack_w[c];
    mreq0 = mem_if.req;
    cl_req[c] = ~cl_req[c];
    @(negedge clk);
    check($sformatf("v%0d mem.req before grant edge", idx), mem_if.req, mreq0);
    @(negedge clk);
    check($sformatf("v%0d mem.req toggled", idx), mem_if.req, !mreq0);
    check($sformatf("v%0d mem.address", idx), mem_if.address, v.addr);
    check($sformatf("v%0d mem.we", idx), mem_if.we, v.we);
    check($sformatf("v%0d mem.data_write", idx), mem_if.data_write, v.dw);
    check($sformatf("v%0d mem.wm", idx), mem_if.wm, v.wm);
    // Fields are sampled only at grant; later changes must not matter.
    cl_addr[c] = ~v.addr; cl_dw[c] = ~v.dw; cl_we[c] = ~v.we;
    seen = 0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(posedge clk); #2;
      seen = (m_ack === mem_if.req);
    end
    check($sformatf("v%0d mem completion seen", idx), seen, 1);
    @(negedge clk);
    check($sformatf("v%0d ack not early", idx), ack_w[c], old_ack);
    @(negedge clk);
    check($sformatf("v%0d ack toggled", idx), ack_w[c], !old_ack);
    check($sformatf("v%0d data_read", idx), dr_w[c], v.exp_dr);
  endtask

  // ---------------- reference model for the random run ----------------
  bit            outst [3];
  int            issue_cyc [3];
  logic          r_we [3];
  logic [AB-1:0] r_addr [3];
  logic [15:0]   r_dw [3];
  logic [1:0]    r_wm [3];
  logic [15:0]   exp_dr [3];
  int            hist [$];      // completion order since reset
  int            in_flight;

  // Next client by the arbitration rules, from the completion history.
  function automatic int model_pick(input bit e0, input bit e1, input bit e2);
    bit e [3];
    int prev;
    e[0] = e0; e[1] = e1; e[2] = e2;
`ifdef SDRAM_ARB_CH0_PRIORITY_EN
    if (e[0]) return 0;
    prev = 2;
    foreach (hist[k]) if (hist[k] != 0) prev = hist[k];
    if (e[1] && e[2]) return (prev == 1) ? 2 : 1;
    if (e[1]) return 1;
    if (e[2]) return 2;
    return -1;
`else
    prev = (hist.size() == 0) ? 2 : hist[hist.size() - 1];
    for (int k = 1; k <= 3; k++) if (e[(prev + k) % 3]) return (prev + k) % 3;
    return -1;
`endif
  endfunction

  initial begin
    vec_t vecs [7];
    int order [$];
    logic [2:0] pa;
    logic pm;
    int ack_cyc, g, drain;
    bit got;
    bit el [3];

    cl_req = 3'b101;             // two requests pending across reset
    cl_we = '0;
    for (int i = 0; i < 3; i++) begin
      cl_addr[i] = '0; cl_dw[i] = '0; cl_wm[i] = '0;
    end

    vecs[0] = '{1, 1'b0, 22'h001234, 16'h0000, 2'b00, 4, 16'hBEEF};
    vecs[1] = '{2, 1'b1, 22'h000ABC, 16'h5A5A, 2'b10, 3, 16'h0000};
    vecs[2] = '{0, 1'b0, 22'h000000, 16'h0000, 2'b00, 1, 16'hACDB};
    vecs[3] = '{2, 1'b0, 22'h3FFFFF, 16'h0000, 2'b00, 2, 16'h5324};
    vecs[4] = '{1, 1'b1, 22'h002000, 16'hFFFF, 2'b01, 5, 16'hBEEF};
    vecs[5] = '{0, 1'b1, 22'h155555, 16'h1234, 2'b00, 1, 16'hACDB};
    vecs[6] = '{0, 1'b0, 22'h2AAAAA, 16'h0000, 2'b00, 3, 16'h0671};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ack==req", ack_w, cl_req);
    check("reset mem.req==mem.ack", mem_if.req, m_ack);
    check("reset mem.we", mem_if.we, 1'b0);
    check("reset mem.wm", mem_if.wm, 2'b00);
    for (int i = 0; i < 3; i++) check($sformatf("reset data_read c%0d", i), dr_w[i], 16'h0);

    // ---- table of isolated transactions ----
    foreach (vecs[i]) do_single(i, vecs[i]);

    // ---- contention: all three at once right after reset ----
    do_reset();
    lat = 2;
    log_addr.delete(); log_cyc.delete();
    @(posedge clk); #1;
    pa = ack_w;
    for (int i = 0; i < 3; i++) begin
      cl_we[i] = 1'b0; cl_addr[i] = 22'(32'h100 * (i + 1));
    end
    cl_req = ~cl_req;
    for (int t = 0; t < 100 && order.size() < 3; t++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (ack_w[i] !== pa[i]) order.push_back(i);
      pa = ack_w;
    end
    check("contention completions", order.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("contention order %0d", k), (order.size() > k) ? order[k] : -1, k);
      check($sformatf("contention mem addr %0d", k),
            (log_addr.size() > k) ? log_addr[k] : '1, 22'(32'h100 * (k + 1)));
    end

    // ---- request arriving while busy ----
    lat = 4;
    log_addr.delete(); log_cyc.delete();
    @(posedge clk); #1;
    pa = ack_w;
    cl_addr[0] = 22'h111;
    cl_req[0] = ~cl_req[0];
    @(posedge clk); @(posedge clk); #1;       // c0 now in flight
    cl_addr[1] = 22'h222;
    cl_req[1] = ~cl_req[1];
    @(posedge clk); #1;
    cl_addr[1] = 22'h333;                    // change while still pending
    ack_cyc = -1;
    got = 0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (ack_w[0] !== pa[0] && ack_cyc < 0) ack_cyc = cyc;
      got = (ack_w[1] !== pa[1]);
    end
    check("busy c1 completed", got, 1);
    check("busy grants", log_addr.size(), 2);
    check("busy c1 captured addr", (log_addr.size() == 2) ? log_addr[1] : '0, 22'h333);
    check("busy c1 grant cycle", (log_cyc.size() == 2) ? log_cyc[1] : -1, ack_cyc + 1);
    check("busy c1 data_read", dr_w[1], 16'hAFE8);

    // ---- reset in the middle of a c1 read ----
    lat = 6;
    @(posedge clk); #1;
    pm = mem_if.req;
    cl_addr[1] = 22'h777;
    cl_req[1] = ~cl_req[1];
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    check("midbusy mem.req toggled", mem_if.req, !pm);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midbusy c1 ack==req", ack_w[1], cl_req[1]);
    check("midbusy mem.req==mem.ack", mem_if.req, m_ack);
    check("midbusy c1 data_read", dr_w[1], 16'h0000);
    repeat (12) @(negedge clk);
    check("midbusy no late ack", ack_w[1], cl_req[1]);
    check("midbusy no late data", dr_w[1], 16'h0000);
    do_single(7, '{2, 1'b0, 22'h000010, 16'h0000, 2'b00, 2, 16'hACCB});

    // ---- randomized run against the reference model ----
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin outst[i] = 0; exp_dr[i] = '0; end
    hist.delete();
    in_flight = -1;
    pa = ack_w;
    pm = mem_if.req;
    drain = 0;
    for (int step = 0; step < 3000; step++) begin
      @(posedge clk); #1;
      if (step < 2500) begin
        lat = $urandom_range(1, 5);
        for (int i = 0; i < 3; i++) begin
          if (!outst[i] && $urandom_range(0, 2) == 0) begin
            r_we[i] = 1'($urandom_range(0, 1));
            r_addr[i] = AB'($urandom);
            r_dw[i] = 16'($urandom);
            r_wm[i] = 2'($urandom_range(0, 3));
            cl_we[i] = r_we[i]; cl_addr[i] = r_addr[i];
            cl_dw[i] = r_dw[i]; cl_wm[i] = r_wm[i];
            cl_req[i] = ~cl_req[i];
            outst[i] = 1;
            issue_cyc[i] = cyc;
          end
        end
      end
      @(negedge clk);
      if (mem_if.req !== pm) begin
        for (int i = 0; i < 3; i++) el[i] = outst[i] && (issue_cyc[i] < cyc);
        g = model_pick(el[0], el[1], el[2]);
        check("rand grant while idle", in_flight, -1);
        check("rand grant has candidate", g >= 0, 1);
        if (g >= 0) begin
          check("rand mem.we", mem_if.we, r_we[g]);
          check("rand mem.address", mem_if.address, r_addr[g]);
          check("rand mem.data_write", mem_if.data_write, r_dw[g]);
          check("rand mem.wm", mem_if.wm, r_wm[g]);
        end
        in_flight = g;
        pm = mem_if.req;
      end
      for (int i = 0; i < 3; i++) begin
        if (ack_w[i] !== pa[i]) begin
          check("rand ack client", i, in_flight);
          if (outst[i] && !r_we[i]) exp_dr[i] = data_for(r_addr[i]);
          outst[i] = 0;
          hist.push_back(i);
          in_flight = -1;
          pa[i] = ack_w[i];
        end
        check($sformatf("rand data_read c%0d", i), dr_w[i], exp_dr[i]);
      end
      if (step >= 2500 && !outst[0] && !outst[1] && !outst[2]) begin
        drain = 1;
        break;
      end
    end
    check("rand drained within bound", drain, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
